// File: rtl/rule_conf_bank.sv
// Double-buffered per-stage type-rule configuration bank with register readback.
// A commit FSM copies shadow to active per stage, only while that stage reports idle.
module rule_conf_bank #(
    parameter int unsigned STAGE_NUM         = 4,
    parameter int unsigned RULE_NUM          = 8,
    parameter int unsigned TYPE_NUM          = 4,
    parameter int unsigned TYPE_WIDTH        = 16,
    parameter int unsigned TYPE_OFFSET_WIDTH = 8,
    parameter int unsigned KEY_FIELD_NUM     = 8,
    parameter int unsigned KEY_OFFSET_WIDTH  = 8,
    parameter int unsigned HEAD_SHIFT_WIDTH  = 8,
    parameter int unsigned META_SHIFT_WIDTH  = 8
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_rst,
    input  logic                                                 i_rule_wren,
    input  logic [31:0]                                          i_rule_addr,
    input  logic [31:0]                                          i_rule_wdata,
    input  logic                                                 i_rule_rden,
    output logic [31:0]                                          o_rule_rdata,
    output logic                                                 o_rule_rvalid,
    input  logic [STAGE_NUM-1:0]                                 i_stage_idle,
    output logic [STAGE_NUM*RULE_NUM-1:0]                        o_typeRule_wren,
    output logic [STAGE_NUM-1:0]                                 o_rule_valid,
    output logic [STAGE_NUM*TYPE_NUM*TYPE_WIDTH-1:0]             o_type_data,
    output logic [STAGE_NUM*TYPE_NUM*TYPE_WIDTH-1:0]             o_type_mask,
    output logic [STAGE_NUM*TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]      o_type_offset,
    output logic [STAGE_NUM*KEY_FIELD_NUM-1:0]                   o_key_offset_v,
    output logic [STAGE_NUM*KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0]  o_key_offset,
    output logic [STAGE_NUM*HEAD_SHIFT_WIDTH-1:0]                o_head_shift,
    output logic [STAGE_NUM*META_SHIFT_WIDTH-1:0]                o_meta_shift,
    output logic                                                 o_commit_busy,
    output logic                                                 o_commit_done,
    output logic                                                 o_cmd_drop
);

    localparam int unsigned SW  = (STAGE_NUM > 1)     ? $clog2(STAGE_NUM)     : 1;
    localparam int unsigned RIW = (RULE_NUM > 1)      ? $clog2(RULE_NUM)      : 1;
    localparam int unsigned TIW = (TYPE_NUM > 1)      ? $clog2(TYPE_NUM)      : 1;
    localparam int unsigned KIW = (KEY_FIELD_NUM > 1) ? $clog2(KEY_FIELD_NUM) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]             sh_tdata, ac_tdata;
    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]             sh_tmask, ac_tmask;
    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]      sh_toff, ac_toff;
    logic [STAGE_NUM-1:0][KEY_FIELD_NUM-1:0]                        sh_kv, ac_kv;
    logic [STAGE_NUM-1:0][KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0]  sh_koff, ac_koff;
    logic [STAGE_NUM-1:0][HEAD_SHIFT_WIDTH-1:0]                     sh_hs, ac_hs;
    logic [STAGE_NUM-1:0][META_SHIFT_WIDTH-1:0]                     sh_ms, ac_ms;
    logic [STAGE_NUM-1:0][RULE_NUM-1:0]                             wren_q;
    logic [STAGE_NUM-1:0]                                           rvld_q;

    logic [1:0]           state_q, state_nxt;
    logic [STAGE_NUM-1:0] pend_q, pend_nxt, copy_c;
    logic                 busy_q, done_q, drop_q, rvalid_q;
    logic [31:0]          rdata_q, rdata_c;

    logic [2:0]     w_stage, w_type;
    logic [5:0]     w_idx;
    logic           rd_bank, stage_ok, idx_ok, wr_ok, drop_c, commit_req;
    logic [SW-1:0]  w_sidx;
    logic [RIW-1:0] w_ridx;
    logic [TIW-1:0] w_tidx;
    logic [KIW-1:0] w_kidx;

    logic unused_ok;
    assign unused_ok = ^{i_rule_addr[31:15], i_rule_addr[7:6]};

    // Address decode shared by the write and readback paths
    always_comb begin
        w_stage    = i_rule_addr[14:12];
        rd_bank    = i_rule_addr[11];
        w_type     = i_rule_addr[10:8];
        w_idx      = i_rule_addr[5:0];
        w_sidx     = w_stage[SW-1:0];
        w_ridx     = w_idx[RIW-1:0];
        w_tidx     = w_idx[TIW-1:0];
        w_kidx     = w_idx[KIW-1:0];
        stage_ok   = 32'(w_stage) < STAGE_NUM;
        idx_ok     = 1'b1;
        case (w_type)
            3'd0:       idx_ok = 32'(w_idx) < RULE_NUM;
            3'd1, 3'd2: idx_ok = 32'(w_idx) < TYPE_NUM;
            3'd3:       idx_ok = 32'(w_idx) < KEY_FIELD_NUM;
            3'd4, 3'd5: idx_ok = (w_idx == 6'd0);
            default:    idx_ok = 1'b1;
        endcase
        commit_req = i_rule_wren && (w_type == 3'd6) && (state_q == ST_IDLE);
        if (w_type == 3'd6) begin
            wr_ok = i_rule_wren && (state_q == ST_IDLE);
        end else begin
            wr_ok = i_rule_wren && stage_ok && idx_ok;
        end
        drop_c = i_rule_wren && !wr_ok;
    end

    // Commit FSM next-state logic
    always_comb begin
        state_nxt = state_q;
        pend_nxt  = pend_q;
        copy_c    = '0;
        case (state_q)
            ST_IDLE: begin
                if (commit_req) begin
                    pend_nxt  = i_rule_wdata[STAGE_NUM-1:0];
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                copy_c   = pend_q & i_stage_idle;
                pend_nxt = pend_q & ~copy_c;
                if (pend_nxt == '0) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pend_q  <= pend_nxt;
            busy_q  <= (state_nxt == ST_WAIT);
            done_q  <= (state_nxt == ST_DONE);
        end
    end

    // Shadow writes and per-stage shadow-to-active copy; copy sees pre-write shadow
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sh_tdata <= '0; ac_tdata <= '0;
            sh_tmask <= '0; ac_tmask <= '0;
            sh_toff  <= '0; ac_toff  <= '0;
            sh_kv    <= '0; ac_kv    <= '0;
            sh_koff  <= '0; ac_koff  <= '0;
            sh_hs    <= '0; ac_hs    <= '0;
            sh_ms    <= '0; ac_ms    <= '0;
        end else begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (copy_c[SW'(s)]) begin
                    ac_tdata[SW'(s)] <= sh_tdata[SW'(s)];
                    ac_tmask[SW'(s)] <= sh_tmask[SW'(s)];
                    ac_toff[SW'(s)]  <= sh_toff[SW'(s)];
                    ac_kv[SW'(s)]    <= sh_kv[SW'(s)];
                    ac_koff[SW'(s)]  <= sh_koff[SW'(s)];
                    ac_hs[SW'(s)]    <= sh_hs[SW'(s)];
                    ac_ms[SW'(s)]    <= sh_ms[SW'(s)];
                end
            end
            if (wr_ok) begin
                case (w_type)
                    3'd1: begin
                        sh_tdata[w_sidx][w_tidx] <= i_rule_wdata[16 +: TYPE_WIDTH];
                        sh_tmask[w_sidx][w_tidx] <= i_rule_wdata[0 +: TYPE_WIDTH];
                    end
                    3'd2: sh_toff[w_sidx][w_tidx] <= i_rule_wdata[0 +: TYPE_OFFSET_WIDTH];
                    3'd3: begin
                        sh_kv[w_sidx][w_kidx]   <= i_rule_wdata[16];
                        sh_koff[w_sidx][w_kidx] <= i_rule_wdata[0 +: KEY_OFFSET_WIDTH];
                    end
                    3'd4: sh_hs[w_sidx] <= i_rule_wdata[0 +: HEAD_SHIFT_WIDTH];
                    3'd5: sh_ms[w_sidx] <= i_rule_wdata[0 +: META_SHIFT_WIDTH];
                    3'd7: begin
                        sh_tdata[w_sidx] <= '0;
                        sh_tmask[w_sidx] <= '0;
                        sh_toff[w_sidx]  <= '0;
                        sh_kv[w_sidx]    <= '0;
                        sh_koff[w_sidx]  <= '0;
                        sh_hs[w_sidx]    <= '0;
                        sh_ms[w_sidx]    <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Readback mux over the write layout; unknown targets read as zero
    always_comb begin
        rdata_c = '0;
        if (stage_ok && idx_ok) begin
            case (w_type)
                3'd0: rdata_c[0] = rvld_q[w_sidx];
                3'd1: begin
                    rdata_c[16 +: TYPE_WIDTH] = rd_bank ? ac_tdata[w_sidx][w_tidx] : sh_tdata[w_sidx][w_tidx];
                    rdata_c[0 +: TYPE_WIDTH]  = rd_bank ? ac_tmask[w_sidx][w_tidx] : sh_tmask[w_sidx][w_tidx];
                end
                3'd2: rdata_c[0 +: TYPE_OFFSET_WIDTH] = rd_bank ? ac_toff[w_sidx][w_tidx] : sh_toff[w_sidx][w_tidx];
                3'd3: begin
                    rdata_c[16] = rd_bank ? ac_kv[w_sidx][w_kidx] : sh_kv[w_sidx][w_kidx];
                    rdata_c[0 +: KEY_OFFSET_WIDTH] = rd_bank ? ac_koff[w_sidx][w_kidx] : sh_koff[w_sidx][w_kidx];
                end
                3'd4: rdata_c[0 +: HEAD_SHIFT_WIDTH] = rd_bank ? ac_hs[w_sidx] : sh_hs[w_sidx];
                3'd5: rdata_c[0 +: META_SHIFT_WIDTH] = rd_bank ? ac_ms[w_sidx] : sh_ms[w_sidx];
                default: rdata_c = '0;
            endcase
        end
    end

    // Rule pulses, drop pulse and readback response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wren_q   <= '0;
            rvld_q   <= '0;
            drop_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wren_q   <= '0;
            drop_q   <= drop_c;
            rvalid_q <= i_rule_rden;
            if (i_rule_rden) rdata_q <= rdata_c;
            if (wr_ok && (w_type == 3'd0)) begin
                wren_q[w_sidx][w_ridx] <= 1'b1;
                rvld_q[w_sidx]         <= i_rule_wdata[0];
            end
        end
    end

    assign o_typeRule_wren = wren_q;
    assign o_rule_valid    = rvld_q;
    assign o_type_data     = ac_tdata;
    assign o_type_mask     = ac_tmask;
    assign o_type_offset   = ac_toff;
    assign o_key_offset_v  = ac_kv;
    assign o_key_offset    = ac_koff;
    assign o_head_shift    = ac_hs;
    assign o_meta_shift    = ac_ms;
    assign o_commit_busy   = busy_q;
    assign o_commit_done   = done_q;
    assign o_cmd_drop      = drop_q;
    assign o_rule_rdata    = rdata_q;
    assign o_rule_rvalid   = rvalid_q;

endmodule

// File: tb/tb_rule_conf_bank.sv
// Directed bench for rule_conf_bank: decode, banking, commit FSM, readback and reset.
module tb_rule_conf_bank;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_rule_wren = 1'b0;
    logic [31:0]  i_rule_addr = '0;
    logic [31:0]  i_rule_wdata = '0;
    logic         i_rule_rden = 1'b0;
    logic [31:0]  o_rule_rdata;
    logic         o_rule_rvalid;
    logic [3:0]   i_stage_idle = '0;
    logic [31:0]  o_typeRule_wren;
    logic [3:0]   o_rule_valid;
    logic [255:0] o_type_data;
    logic [255:0] o_type_mask;
    logic [127:0] o_type_offset;
    logic [31:0]  o_key_offset_v;
    logic [255:0] o_key_offset;
    logic [31:0]  o_head_shift;
    logic [31:0]  o_meta_shift;
    logic         o_commit_busy;
    logic         o_commit_done;
    logic         o_cmd_drop;

    int checks = 0;
    int failures = 0;

    rule_conf_bank dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rule_wren(i_rule_wren), .i_rule_addr(i_rule_addr), .i_rule_wdata(i_rule_wdata),
        .i_rule_rden(i_rule_rden), .o_rule_rdata(o_rule_rdata), .o_rule_rvalid(o_rule_rvalid),
        .i_stage_idle(i_stage_idle), .o_typeRule_wren(o_typeRule_wren), .o_rule_valid(o_rule_valid),
        .o_type_data(o_type_data), .o_type_mask(o_type_mask), .o_type_offset(o_type_offset),
        .o_key_offset_v(o_key_offset_v), .o_key_offset(o_key_offset),
        .o_head_shift(o_head_shift), .o_meta_shift(o_meta_shift),
        .o_commit_busy(o_commit_busy), .o_commit_done(o_commit_done), .o_cmd_drop(o_cmd_drop)
    );

    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        i_rule_wren = 1'b1; i_rule_addr = a; i_rule_wdata = d;
        cyc();
        i_rule_wren = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
        i_rule_rden = 1'b1; i_rule_addr = a;
        cyc();
        i_rule_rden = 1'b0;
        d = o_rule_rdata; v = o_rule_rvalid;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        repeat (3) cyc();
        checks++; if ({o_type_data, o_type_mask, o_type_offset, o_key_offset, o_key_offset_v} !== '0) begin
            failures++; $display("FAIL reset_active: got nonzero, expected 0"); end
        checks++; if ({o_commit_busy, o_commit_done, o_cmd_drop, o_rule_rvalid, o_typeRule_wren, o_rule_valid} !== '0) begin
            failures++; $display("FAIL reset_ctrl: got nonzero, expected 0"); end
        i_rst = 1'b0;
        cyc();
        rd(32'h0000_0800, d, v);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin
            failures++; $display("FAIL reset_read: got v=%b d=%h, expected v=1 d=0", v, d); end
        cyc();
        checks++; if (o_rule_rvalid !== 1'b0) begin
            failures++; $display("FAIL rvalid_one_cycle: got %b, expected 0", o_rule_rvalid); end
    endtask

    task automatic test_shadow_write();
        logic [31:0] d; logic v;
        wr(32'h0000_1102, 32'h8847_0FFF);
        checks++; if (o_cmd_drop !== 1'b0) begin
            failures++; $display("FAIL shadow_nodrop: got %b, expected 0", o_cmd_drop); end
        rd(32'h0000_1102, d, v);
        checks++; if (v !== 1'b1 || d !== 32'h8847_0FFF) begin
            failures++; $display("FAIL shadow_read: got %h, expected 88470fff", d); end
        rd(32'h0000_1902, d, v);
        checks++; if (d !== 32'h0) begin
            failures++; $display("FAIL active_read_pre: got %h, expected 0", d); end
        checks++; if (o_type_data !== '0) begin
            failures++; $display("FAIL type_data_pre: got nonzero, expected 0"); end
        wr(32'h0000_0100, 32'h1234_5678);
        wr(32'h0000_0400, 32'h0000_005A);
        wr(32'h0000_2400, 32'h0000_0077);
    endtask

    task automatic test_rule_wren();
        logic [31:0] d; logic v;
        wr(32'h0000_3005, 32'h1);
        checks++; if (o_typeRule_wren !== 32'h2000_0000 || o_rule_valid !== 4'b1000) begin
            failures++; $display("FAIL rule_pulse: got wren=%h valid=%b, expected 20000000/1000", o_typeRule_wren, o_rule_valid); end
        cyc();
        checks++; if (o_typeRule_wren !== 32'h0 || o_rule_valid !== 4'b1000) begin
            failures++; $display("FAIL rule_pulse_end: got wren=%h valid=%b, expected 0/1000", o_typeRule_wren, o_rule_valid); end
        rd(32'h0000_3005, d, v);
        checks++; if (d !== 32'h1) begin
            failures++; $display("FAIL rule_read: got %h, expected 1", d); end
    endtask

    task automatic test_drop();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0000_4100; addrs[1] = 32'h0000_0104; addrs[2] = 32'h0000_0008;
        for (int i = 0; i < 3; i++) begin
            wr(addrs[i], 32'hFFFF_FFFF);
            checks++; if (o_cmd_drop !== 1'b1) begin
                failures++; $display("FAIL drop_%0d: got %b, expected 1", i, o_cmd_drop); end
            cyc();
            checks++; if (o_cmd_drop !== 1'b0) begin
                failures++; $display("FAIL drop_end_%0d: got %b, expected 0", i, o_cmd_drop); end
        end
        checks++; if (o_typeRule_wren !== 32'h0 || o_rule_valid !== 4'b1000) begin
            failures++; $display("FAIL drop_side: got wren=%h valid=%b", o_typeRule_wren, o_rule_valid); end
    endtask

    task automatic test_commit();
        int dones = 0;
        i_stage_idle = 4'b0001;
        wr(32'h0000_0600, 32'h3);
        checks++; if (o_commit_busy !== 1'b1 || o_type_data[15:0] !== 16'h0) begin
            failures++; $display("FAIL commit_start: got busy=%b d0=%h, expected 1/0", o_commit_busy, o_type_data[15:0]); end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                i_rule_wren = 1'b1; i_rule_addr = 32'h0000_0600; i_rule_wdata = 32'hF;
            end
            cyc();
            i_rule_wren = 1'b0;
            if (o_commit_done) dones++;
            if (k == 0) begin
                checks++; if (o_type_data[15:0] !== 16'h1234 || o_type_mask[15:0] !== 16'h5678 || o_head_shift[7:0] !== 8'h5A) begin
                    failures++; $display("FAIL stage0_copy: got %h/%h/%h, expected 1234/5678/5a",
                        o_type_data[15:0], o_type_mask[15:0], o_head_shift[7:0]); end
            end
            if (k == 1) begin
                checks++; if (o_cmd_drop !== 1'b1) begin
                    failures++; $display("FAIL commit_in_wait_drop: got %b, expected 1", o_cmd_drop); end
            end
            checks++; if (o_commit_busy !== 1'b1 || o_type_data[111:96] !== 16'h0) begin
                failures++; $display("FAIL wait_k%0d: got busy=%b d1=%h, expected 1/0", k, o_commit_busy, o_type_data[111:96]); end
        end
        i_stage_idle = 4'b0011;
        cyc();
        if (o_commit_done) dones++;
        checks++; if (o_commit_busy !== 1'b0 || o_type_data[111:96] !== 16'h8847 || o_type_mask[111:96] !== 16'h0FFF) begin
            failures++; $display("FAIL stage1_copy: got busy=%b d=%h m=%h, expected 0/8847/0fff",
                o_commit_busy, o_type_data[111:96], o_type_mask[111:96]); end
        cyc();
        if (o_commit_done) dones++;
        checks++; if (dones != 1 || o_head_shift[23:16] !== 8'h0) begin
            failures++; $display("FAIL done_once: got dones=%0d hs2=%h, expected 1/0", dones, o_head_shift[23:16]); end
    endtask

    task automatic test_mask_zero();
        i_stage_idle = 4'b0000;
        wr(32'h0000_0600, 32'h0);
        checks++; if (o_commit_busy !== 1'b1 || o_commit_done !== 1'b0) begin
            failures++; $display("FAIL mask0_c1: got busy=%b done=%b, expected 1/0", o_commit_busy, o_commit_done); end
        cyc();
        checks++; if (o_commit_busy !== 1'b0 || o_commit_done !== 1'b1) begin
            failures++; $display("FAIL mask0_c2: got busy=%b done=%b, expected 0/1", o_commit_busy, o_commit_done); end
        cyc();
        checks++; if (o_commit_done !== 1'b0) begin
            failures++; $display("FAIL mask0_c3: got done=%b, expected 0", o_commit_done); end
    endtask

    task automatic test_copy_collision();
        logic [31:0] d; logic v;
        i_stage_idle = 4'b1111;
        wr(32'h0000_0400, 32'h5B);
        wr(32'h0000_0600, 32'h1);
        wr(32'h0000_0400, 32'h99);
        checks++; if (o_head_shift[7:0] !== 8'h5B || o_commit_done !== 1'b1) begin
            failures++; $display("FAIL collide_active: got hs=%h done=%b, expected 5b/1", o_head_shift[7:0], o_commit_done); end
        rd(32'h0000_0400, d, v);
        checks++; if (d !== 32'h99) begin
            failures++; $display("FAIL collide_shadow: got %h, expected 99", d); end
    endtask

    task automatic test_back_to_back_rw();
        logic [31:0] d; logic v;
        i_rule_wren = 1'b1; i_rule_rden = 1'b1;
        i_rule_addr = 32'h0000_1102; i_rule_wdata = 32'hAAAA_5555;
        cyc();
        i_rule_wren = 1'b0; i_rule_rden = 1'b0;
        checks++; if (o_rule_rvalid !== 1'b1 || o_rule_rdata !== 32'h8847_0FFF) begin
            failures++; $display("FAIL rw_old: got %h, expected 88470fff", o_rule_rdata); end
        rd(32'h0000_1102, d, v);
        checks++; if (d !== 32'hAAAA_5555) begin
            failures++; $display("FAIL rw_new: got %h, expected aaaa5555", d); end
        wr(32'h0000_1700, 32'h0);
        rd(32'h0000_1102, d, v);
        checks++; if (d !== 32'h0) begin
            failures++; $display("FAIL clear_shadow: got %h, expected 0", d); end
        rd(32'h0000_1902, d, v);
        checks++; if (d !== 32'h8847_0FFF) begin
            failures++; $display("FAIL clear_keeps_active: got %h, expected 88470fff", d); end
    endtask

    task automatic test_reset_mid_commit();
        logic [31:0] d; logic v;
        int dones = 0;
        i_stage_idle = 4'b0000;
        wr(32'h0000_0600, 32'h4);
        cyc();
        checks++; if (o_commit_busy !== 1'b1 || o_type_data[15:0] !== 16'h1234) begin
            failures++; $display("FAIL pre_rst: got busy=%b d0=%h, expected 1/1234", o_commit_busy, o_type_data[15:0]); end
        #2 i_rst = 1'b1;
        #1;
        checks++; if (o_commit_busy !== 1'b0 || o_type_data !== '0 || o_head_shift !== '0 || o_rule_valid !== '0) begin
            failures++; $display("FAIL async_rst: got busy=%b hs=%h, expected all 0", o_commit_busy, o_head_shift); end
        repeat (2) begin cyc(); if (o_commit_done) dones++; end
        i_rst = 1'b0;
        repeat (3) begin cyc(); if (o_commit_done) dones++; end
        checks++; if (dones != 0 || o_commit_busy !== 1'b0) begin
            failures++; $display("FAIL rst_no_done: got dones=%0d busy=%b, expected 0/0", dones, o_commit_busy); end
        rd(32'h0000_2400, d, v);
        checks++; if (d !== 32'h0) begin
            failures++; $display("FAIL rst_shadow: got %h, expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_shadow_write();
        test_rule_wren();
        test_drop();
        test_commit();
        test_mask_zero();
        test_copy_collision();
        test_back_to_back_rw();
        test_reset_mid_commit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
